// File: rtl/vga_pattern_timing_gen.sv
// VGA 640x480 timing generator with selectable test patterns.
// Sync, video, pixel coordinates and frame-start all come from the same
// counter state through one register stage, so they always describe the same pixel.
module vga_pattern_timing_gen #(
   parameter int unsigned VIDEO_WIDTH = 3,
   parameter int unsigned TOTAL_COLS  = 800,
   parameter int unsigned TOTAL_ROWS  = 525,
   parameter int unsigned ACTIVE_COLS = 640,
   parameter int unsigned ACTIVE_ROWS = 480
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             i_Pattern,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
   output logic [9:0]             o_Col_Count,
   output logic [9:0]             o_Row_Count,
   output logic                   o_Frame_Start
);

   localparam int unsigned CW         = 10;
   localparam int unsigned OW         = CW + 1;
   localparam int unsigned BAR_W      = ACTIVE_COLS / 8;
   localparam int unsigned BAR_LEN    = 16;
   localparam int unsigned BAR_STEP   = 4;
   localparam int unsigned OFFSET_MAX = ACTIVE_COLS - BAR_LEN;
   localparam logic [VIDEO_WIDTH-1:0] VMAX = '1;

   logic [CW-1:0]          r_Col;
   logic [CW-1:0]          r_Row;
   logic [2:0]             r_Pattern;
   logic [CW-1:0]          r_Offset;

   logic                   w_Col_Last;
   logic                   w_Row_Last;
   logic                   w_Frame_Origin;
   logic [2:0]             w_Pattern;
   logic                   w_Active;
   logic                   w_Border;
   logic                   w_In_Bar;
   logic [OW-1:0]          w_Offset_Next;
   logic [2:0]             w_Bar_Idx;
   logic [VIDEO_WIDTH-1:0] w_Red;
   logic [VIDEO_WIDTH-1:0] w_Grn;
   logic [VIDEO_WIDTH-1:0] w_Blu;

   assign w_Col_Last     = (r_Col == CW'(TOTAL_COLS - 1));
   assign w_Row_Last     = (r_Row == CW'(TOTAL_ROWS - 1));
   assign w_Frame_Origin = (r_Col == '0) && (r_Row == '0);
   // A new selection is only honoured at the first pixel of a frame.
   assign w_Pattern      = w_Frame_Origin ? i_Pattern : r_Pattern;
   assign w_Active       = (r_Col < CW'(ACTIVE_COLS)) && (r_Row < CW'(ACTIVE_ROWS));
   assign w_Border       = (r_Col == '0) || (r_Col == CW'(ACTIVE_COLS - 1)) ||
                           (r_Row == '0) || (r_Row == CW'(ACTIVE_ROWS - 1));
   assign w_In_Bar       = (r_Col >= r_Offset) &&
                           ({1'b0, r_Col} < ({1'b0, r_Offset} + OW'(BAR_LEN)));
   assign w_Offset_Next  = {1'b0, r_Offset} + OW'(BAR_STEP);

   // Column/row raster counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_Col <= '0;
         r_Row <= '0;
      end else begin
         r_Col <= w_Col_Last ? '0 : r_Col + CW'(1);
         if (w_Col_Last) begin
            r_Row <= w_Row_Last ? '0 : r_Row + CW'(1);
         end
      end
   end

   // Pattern latch at frame origin and per-frame bar offset advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_Pattern <= '0;
         r_Offset  <= '0;
      end else begin
         if (w_Frame_Origin) begin
            r_Pattern <= i_Pattern;
         end
         if (w_Col_Last && w_Row_Last) begin
            r_Offset <= (w_Offset_Next > OW'(OFFSET_MAX)) ? '0 : CW'(w_Offset_Next);
         end
      end
   end

   // Vertical bar index from a comparator chain; smallest matching bound wins.
   always_comb begin
      w_Bar_Idx = 3'd7;
      for (int k = 6; k >= 0; k--) begin
         if (r_Col < CW'(BAR_W * (k + 1))) begin
            w_Bar_Idx = 3'(k);
         end
      end
   end

   // Pixel colour for the current counter position; black outside the active region.
   always_comb begin
      w_Red = '0;
      w_Grn = '0;
      w_Blu = '0;
      if (w_Active) begin
         case (w_Pattern)
            3'd1: w_Red = VMAX;
            3'd2: w_Grn = VMAX;
            3'd3: w_Blu = VMAX;
            3'd4: begin
               if (r_Col[5] ^ r_Row[5]) begin
                  w_Red = VMAX;
                  w_Grn = VMAX;
                  w_Blu = VMAX;
               end
            end
            3'd5: begin
               w_Red = {VIDEO_WIDTH{w_Bar_Idx[2]}};
               w_Grn = {VIDEO_WIDTH{w_Bar_Idx[1]}};
               w_Blu = {VIDEO_WIDTH{w_Bar_Idx[0]}};
            end
            3'd6: begin
               if (w_Border) begin
                  w_Red = VMAX;
                  w_Grn = VMAX;
                  w_Blu = VMAX;
               end
            end
            3'd7: begin
               if (w_In_Bar) begin
                  w_Red = VMAX;
                  w_Grn = VMAX;
                  w_Blu = VMAX;
               end
            end
            default: begin
               w_Red = '0;
               w_Grn = '0;
               w_Blu = '0;
            end
         endcase
      end
   end

   // Output register stage: everything describes the pixel at the counter state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_HSync       <= 1'b0;
         o_VSync       <= 1'b0;
         o_Red_Video   <= '0;
         o_Grn_Video   <= '0;
         o_Blu_Video   <= '0;
         o_Col_Count   <= '0;
         o_Row_Count   <= '0;
         o_Frame_Start <= 1'b0;
      end else begin
         o_HSync       <= (r_Col < CW'(ACTIVE_COLS));
         o_VSync       <= (r_Row < CW'(ACTIVE_ROWS));
         o_Red_Video   <= w_Red;
         o_Grn_Video   <= w_Grn;
         o_Blu_Video   <= w_Blu;
         o_Col_Count   <= r_Col;
         o_Row_Count   <= r_Row;
         o_Frame_Start <= w_Frame_Origin;
      end
   end

endmodule
